// File: rtl/mac_accum.sv
// Signed multiply-accumulate stage: sums NUM_TERMS products a*b at full precision
// and presents each dot-product result on a valid/ready output port.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | no terms accumulated, ready for the first pair
// ST_ACCUM  | 1..NUM_TERMS-1 terms accumulated, ready for more pairs
// ST_HOLD   | result presented with out_valid, waiting for out_ready
module mac_accum #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_TERMS  = 8,
    localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_TERMS) + 1,
    localparam int CNT_WIDTH  = $clog2(NUM_TERMS+1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] result,
    output logic        [CNT_WIDTH-1:0] term_cnt
);

    localparam int PROD_WIDTH = 2*DATA_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_TERMS - 1);

    logic        [1:0]            state;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  product_ext;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic                         accept;
    logic                         last_term;

    assign product     = a * b;
    assign product_ext = {{(ACC_WIDTH-PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
    assign acc_sum     = acc + product_ext;

    // Ready depends only on state so upstream never sees a loop through in_valid.
    assign in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
    assign accept    = in_valid && in_ready && !clr;
    assign last_term = (term_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            term_cnt  <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            // Abort keeps the last delivered result visible.
            state     <= ST_IDLE;
            acc       <= '0;
            term_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        if (last_term) begin
                            result    <= acc_sum;
                            acc       <= '0;
                            term_cnt  <= '0;
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end else begin
                            acc      <= acc_sum;
                            term_cnt <= term_cnt + 1'b1;
                            state    <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    acc       <= '0;
                    term_cnt  <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based batch model.
module tb_mac_accum;

    localparam int DW    = 8;
    localparam int NT    = 4;
    localparam int ACC_W = 2*DW + $clog2(NT) + 1;
    localparam int CNT_W = $clog2(NT+1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clr;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [DW-1:0]   a;
    logic signed [DW-1:0]   b;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [ACC_W-1:0] result;
    logic        [CNT_W-1:0] term_cnt;

    int checks = 0;
    int fails  = 0;

    mac_accum #(.DATA_WIDTH(DW), .NUM_TERMS(NT)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .term_cnt  (term_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the products of the open batch, whether a result is
    // being presented, and the last delivered result.
    int  m_terms[$];
    bit  m_hold   = 1'b0;
    int  m_result = 0;
    bit  m_known  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_terms.delete();
            m_hold   = 1'b0;
            m_result = 0;
            m_known  = 1'b1;
        end else if (clr) begin
            m_terms.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            m_terms.push_back(int'(a) * int'(b));
            if (m_terms.size() == NT) begin
                m_result = 0;
                foreach (m_terms[i]) m_result += m_terms[i];
                m_terms.delete();
                m_hold = 1'b1;
            end
        end
        #1;
        if (m_known) begin
            chk("model_out_valid", int'(out_valid), int'(m_hold));
            chk("model_in_ready",  int'(in_ready),  int'(!m_hold));
            chk("model_term_cnt",  int'(term_cnt),  m_terms.size());
            chk("model_result",    int'(result),    m_result);
        end
    end

    task automatic pair(input int va, input int vb);
        in_valid = 1'b1;
        a = DW'(va);
        b = DW'(vb);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready",  int'(in_ready), 1);
        chk("reset_result",    int'(result), 0);
        chk("reset_term_cnt",  int'(term_cnt), 0);
        rst = 1'b0;
        idle(1);

        // Back-to-back batch, downstream always ready.
        pair(3, 4); pair(-2, 5); pair(127, 127); pair(-128, -128);
        in_valid = 1'b0;
        chk("b2b_out_valid", int'(out_valid), 1);
        chk("b2b_result",    int'(result), 32515);
        chk("b2b_in_ready",  int'(in_ready), 0);
        @(negedge clk);
        chk("b2b_idle_valid", int'(out_valid), 0);
        chk("b2b_idle_ready", int'(in_ready), 1);

        // Backpressure: pairs presented during HOLD are ignored.
        out_ready = 1'b0;
        pair(3, 4); pair(-2, 5); pair(127, 127); pair(-128, -128);
        for (int i = 0; i < 5; i++) begin
            a = DW'(i + 7); b = DW'(9);
            chk("hold_valid",    int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_term_cnt", int'(term_cnt), 0);
            chk("hold_result",   int'(result), 32515);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_out_valid", int'(out_valid), 0);
        chk("hs_term_cnt",  int'(term_cnt), 0);
        in_valid = 1'b0;
        @(negedge clk);

        // Bubbles between accepts.
        for (int k = 1; k <= 4; k++) begin
            pair(-1, 1);
            in_valid = 1'b0;
            chk("bubble_term_cnt", int'(term_cnt), k % 4);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        chk("bubble_result", int'(result), -4);
        idle(2);

        // Abort mid-batch drops the partial sum and the clr-cycle pair.
        pair(10, 10); pair(10, 10);
        in_valid = 1'b0;
        chk("clr_pre_cnt", int'(term_cnt), 2);
        clr = 1'b1; in_valid = 1'b1; a = DW'(50); b = DW'(50);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_term_cnt",  int'(term_cnt), 0);
        chk("clr_result",    int'(result), -4);
        pair(1, 1); pair(1, 1); pair(1, 1); pair(1, 1);
        in_valid = 1'b0;
        chk("clr_next_result", int'(result), 4);
        idle(2);

        // Reset while presenting a result.
        out_ready = 1'b0;
        pair(1, 2); pair(1, 2); pair(1, 2); pair(1, 2);
        in_valid = 1'b0;
        chk("rsthold_valid",  int'(out_valid), 1);
        chk("rsthold_result", int'(result), 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result",    int'(result), 0);
        chk("rst_in_ready",  int'(in_ready), 1);

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) != 0) ? DW'(-128) : DW'(127);
                b = ($urandom_range(0, 1) != 0) ? DW'(-128) : DW'(127);
            end else begin
                a = DW'($urandom);
                b = DW'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 255) == 0);
            @(negedge clk);
        end
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
